// File: rtl/ti_sbox_pipe.sv
// Pipelined 3-share threshold implementation of a quadratic 4-bit S-box component.
// Every share of every stage is computed from the other two shares only; stages are register-separated.
module ti_sbox_pipe #(
  parameter int unsigned NIBBLES = 16,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned REFRESH = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [4*NIBBLES-1:0]            x1,
  input  logic [4*NIBBLES-1:0]            x2,
  input  logic [4*NIBBLES-1:0]            x3,
  input  logic [2*4*NIBBLES*STAGES-1:0]   rnd,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [4*NIBBLES-1:0]            y1,
  output logic [4*NIBBLES-1:0]            y2,
  output logic [4*NIBBLES-1:0]            y3,
  output logic                            busy
);

  localparam int unsigned W = 4 * NIBBLES;

  // Q(x): q0=x0^x1x2, q1=x1^x2x3, q2=x2^x3x0, q3=x3^x0x1. The share function takes its own
  // linear term from a and the three cross products that the cyclic share pairing makes complete.
  function automatic logic [3:0] q294_box(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    r[0] = a[0] ^ (a[1] & a[2]) ^ (a[1] & b[2]) ^ (b[1] & a[2]);
    r[1] = a[1] ^ (a[2] & a[3]) ^ (a[2] & b[3]) ^ (b[2] & a[3]);
    r[2] = a[2] ^ (a[3] & a[0]) ^ (a[3] & b[0]) ^ (b[3] & a[0]);
    r[3] = a[3] ^ (a[0] & a[1]) ^ (a[0] & b[1]) ^ (b[0] & a[1]);
    return r;
  endfunction

  function automatic logic [W-1:0] share_fn(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int n = 0; n < int'(NIBBLES); n++) begin
      r[4*n +: 4] = q294_box(a[4*n +: 4], b[4*n +: 4]);
    end
    return r;
  endfunction

  logic [STAGES-1:0] vld;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    logic [W-1:0] i1, i2, i3;
    logic [W-1:0] ra, rb;
    logic [W-1:0] s1, s2, s3;
    logic         v, v_up, adv, adv_out;

    if (k == 0) begin : g_first
      assign i1   = x1;
      assign i2   = x2;
      assign i3   = x3;
      assign v_up = in_valid;
    end else begin : g_next
      assign i1   = g_stage[k-1].s1;
      assign i2   = g_stage[k-1].s2;
      assign i3   = g_stage[k-1].s3;
      assign v_up = g_stage[k-1].v;
    end

    if (k == int'(STAGES) - 1) begin : g_last
      assign adv_out = out_ready;
    end else begin : g_inner
      assign adv_out = g_stage[k+1].adv;
    end

    if (REFRESH != 0) begin : g_refresh
      assign ra = rnd[2*W*k +: W];
      assign rb = rnd[2*W*k + W +: W];
    end else begin : g_plain
      assign ra = '0;
      assign rb = '0;
    end

    // A stage moves whenever it is empty or its successor can take its content.
    assign adv    = ~v | adv_out;
    assign vld[k] = v;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v  <= 1'b0;
        s1 <= '0;
        s2 <= '0;
        s3 <= '0;
      end else if (adv) begin
        v  <= v_up;
        s1 <= share_fn(i2, i3) ^ ra;
        s2 <= share_fn(i3, i1) ^ rb;
        s3 <= share_fn(i1, i2) ^ ra ^ rb;
      end
    end
  end

  if (REFRESH == 0) begin : g_no_rnd
    logic unused_rnd;
    assign unused_rnd = ^rnd;
  end

  assign in_ready  = g_stage[0].adv;
  assign out_valid = vld[STAGES-1];
  assign busy      = |vld;
  assign y1        = g_stage[STAGES-1].s1;
  assign y2        = g_stage[STAGES-1].s2;
  assign y3        = g_stage[STAGES-1].s3;

endmodule

// File: doc/ti_sbox_pipe.md
# ti_sbox_pipe

Parametrised, pipelined 3-share threshold implementation of a 4-bit quadratic S-box component, applied to `NIBBLES` nibbles in parallel and iterated over `STAGES` register-separated rounds.
- Each stage uses the team's 3-share, non-complete quadratic share function `Q294_box`. Share i is computed from the other two shares only.
- A register sits between every stage, so glitches cannot cross non-complete boundaries.
- Optional per-stage re-masking from fresh randomness.
- An elastic valid/ready pipeline lets the block sit between the Midori64 state register and the permutation layer with back-pressure.

## Interface
Parameters:
- `NIBBLES`, default 16: nibbles per share; share width W = 4*NIBBLES.
- `STAGES`, default 2: number of quadratic stages; must be >= 1. Pipeline latency equals `STAGES`.
- `REFRESH`, default 1: when 1, output shares of each stage are re-masked; when 0, `rnd` is ignored.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input shares valid.
- `in_ready`  out  1  block accepts input this cycle.
- `x1`, `x2`, `x3`  in  W each  input shares.
- `rnd`  in  2*W*STAGES  fresh randomness; slice k (2*W bits) belongs to stage k.
- `out_valid`  out  1  output shares valid.
- `out_ready`  in  1  downstream accepts output.
- `y1`, `y2`, `y3`  out  W each  output shares.
- `busy`  out  1  at least one stage holds valid data.

## Operation
- Stage k (k = 0..STAGES-1) holds registers s1/s2/s3 (W bits each) and a valid bit v[k].
- Stage k input is (x1,x2,x3) for k=0, else stage k-1 registers.
- For each nibble n, independently:
  - Share 1: c1 = Q294_box(in2, in3).
  - Share 2: c2 = Q294_box(in3, in1).
  - Share 3: c3 = Q294_box(in1, in2).
- Refresh with REFRESH=1: ra = rnd[k][W-1:0], rb = rnd[k][2W-1:W]. Stored values are s1 = c1^ra, s2 = c2^rb, s3 = c3^ra^rb.
- With REFRESH=0, s = c.
- Correctness invariant: y1^y2^y3 = Q^STAGES(x1^x2^x3) per nibble, where Q is the unshared function of the component.
- Refresh never changes the unshared value.
- Elastic control:
  - adv[k] = v[k]==0 or adv-out of k, where adv-out of the last stage is `out_ready`, and of stage k < last is adv[k+1].
  - Stage k loads when adv[k]. v[k] takes the upstream valid: `in_valid` for k=0, else v[k-1].
  - When adv[k]=0, stage k holds its data and valid bit.
- `in_ready` = adv[0], combinational from `out_ready` and the valid bits. It is a full-throughput pipeline with no bubbles.
- `out_valid` = v[STAGES-1]. y1/y2/y3 are the last-stage registers, with no logic after the register.
- `busy` = OR of all v[k].
- Randomness consumption: rnd slice k is sampled only on cycles where stage k loads.
  - The source must present fresh bits each cycle.
  - Bits presented on non-loading cycles are discarded.
- No path combines all three shares of one value in one combinational cone.
- Synthesis must keep per-share logic separate.

## Timing
- Reset (`rst_n`=0, asynchronous): all v[k]=0 and all share registers = 0.
  - Outputs: `out_valid`=0, `busy`=0, y1=y2=y3=0.
  - `in_ready`=1 once reset is released, and is 1 during reset as well (combinational from the cleared valid bits).
- Reset asserted mid-operation drops all in-flight data immediately. The first accepted input after release appears after `STAGES` cycles.
- Latency: an input accepted at edge t (in_valid & in_ready) is presented on y with out_valid=1 after edge t+STAGES-1. It is consumable at edge t+STAGES when out_ready=1 throughout.
- Throughput: one item per cycle when out_ready stays high.
- Back-pressure boundary cases:
  - Full pipeline with out_ready=0: in_ready=0 and all stages hold.
  - Simultaneous out_ready rising and in_valid in a full pipeline: the output is consumed and the input accepted in the same cycle.
  - Empty intermediate stages fill while the last stage stalls. in_ready stays 1 until every stage is valid.
- Transfer occurs only on valid&ready. Input shares are don't-care when in_valid=0.

## Test plan
- Exhaustive correctness: NIBBLES=1, STAGES=1, REFRESH=0. Drive all 4096 share triples (x1,x2,x3) with out_ready=1 -> each y1^y2^y3 equals golden Q(x1^x2^x3); first out_valid exactly 1 cycle after acceptance.
- Refresh invariance: NIBBLES=16, STAGES=2, REFRESH=1, x1=0x0123456789ABCDEF, x2=x3=0, rnd random -> unshared output equals the golden Q(Q(·)) per nibble. Rerun with rnd=0 -> y shares differ but the XOR is identical.
- Back-pressure: STAGES=2, stream 10 items, out_ready=0 for cycles 3-7 -> in_ready drops after 2 stalled items fill the pipe. All 10 outputs arrive in order with no loss or duplication.
- Reset mid-operation: 2 items in flight, pulse rst_n low for 1 cycle, not edge-aligned -> out_valid=0, y=0, busy=0 immediately. The next item appears exactly STAGES cycles after acceptance.
- Throughput: out_ready=1, in_valid=1 for 100 cycles -> 100 outputs in 100 consecutive cycles after the STAGES-cycle latency.
- Non-completeness check: force x1 to X in simulation -> y1 register of stage 0 never goes X.
